fft_stage_controller: RTL and testbench

- In-place radix-2 DIT FFT sequencer. It is the initiator that drives fft_butterfly.
- Per stage, it reads operand pairs and twiddles from the sample RAM and twiddle ROM, issues one butterfly per cycle, and writes results back to the same addresses.
- It runs all LOG2_N stages, then pulses done.
- Sits between the capture buffer (input already stored in bit-reversed order) and the magnitude/display path.

---
 rtl/fft_pkg.sv | 37 +++
 rtl/fft_addr_gen.sv | 31 +++
 rtl/fft_stage_controller.sv | 134 +++++++++++++
 tb/tb_fft_stage_controller.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants, complex-word helpers and controller state
// encoding for the in-place radix-2 FFT datapath.
package fft_pkg;

  localparam int FFT_POINTS    = 1024;
  localparam int LOG2_N        = 10;
  localparam int DATA_WIDTH    = 24;
  localparam int TWIDDLE_WIDTH = 24;
  localparam int BFLY_LATENCY  = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } ctrl_state_e;

  function automatic logic [2*DATA_WIDTH-1:0] cplx_pack(
    input logic signed [DATA_WIDTH-1:0] re,
    input logic signed [DATA_WIDTH-1:0] im
  );
    return {re, im};
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] cplx_re(
    input logic [2*DATA_WIDTH-1:0] w
  );
    return w[2*DATA_WIDTH-1 -: DATA_WIDTH];
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] cplx_im(
    input logic [2*DATA_WIDTH-1:0] w
  );
    return w[DATA_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Butterfly operand and twiddle addressing for one DIT stage:
// stage s, butterfly k -> (addr_a, addr_b, tw_addr).
module fft_addr_gen #(
  parameter int LOG2_N = 10,
  parameter int SW     = 4
) (
  input  logic [SW-1:0]     stage,
  input  logic [LOG2_N-2:0] k,
  output logic [LOG2_N-1:0] addr_a,
  output logic [LOG2_N-1:0] addr_b,
  output logic [LOG2_N-2:0] tw_addr
);

  logic [LOG2_N-1:0] kx;
  logic [LOG2_N-1:0] half;
  logic [LOG2_N-1:0] pos;
  logic [LOG2_N-1:0] grp;
  logic [LOG2_N-1:0] tw_full;

  always_comb begin
    kx      = {1'b0, k};
    half    = LOG2_N'(1) << stage;
    pos     = kx & (half - LOG2_N'(1));
    grp     = kx >> stage;
    addr_a  = ((grp << stage) << 1) | pos;
    addr_b  = addr_a | half;
    tw_full = pos << (LOG2_N - 1 - int'(stage));
    tw_addr = tw_full[LOG2_N-2:0];
  end

endmodule

// File: rtl/fft_stage_controller.sv
// In-place radix-2 DIT FFT sequencer: walks all stages, feeds the
// butterfly from RAM/ROM and writes its results back in place.
module fft_stage_controller #(
  parameter int FFT_POINTS    = fft_pkg::FFT_POINTS,
  parameter int LOG2_N        = fft_pkg::LOG2_N,
  parameter int DATA_WIDTH    = fft_pkg::DATA_WIDTH,
  parameter int TWIDDLE_WIDTH = fft_pkg::TWIDDLE_WIDTH,
  parameter int BFLY_LATENCY  = fft_pkg::BFLY_LATENCY
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       i_start,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_rd_en,
  output logic [LOG2_N-1:0]          o_rd_addr_a,
  output logic [LOG2_N-1:0]          o_rd_addr_b,
  input  logic [2*DATA_WIDTH-1:0]    i_rd_data_a,
  input  logic [2*DATA_WIDTH-1:0]    i_rd_data_b,
  output logic [LOG2_N-2:0]          o_tw_addr,
  input  logic [2*TWIDDLE_WIDTH-1:0] i_twiddle,
  output logic                       o_bf_start,
  output logic [2*DATA_WIDTH-1:0]    o_bf_data_a,
  output logic [2*DATA_WIDTH-1:0]    o_bf_data_b,
  output logic [2*TWIDDLE_WIDTH-1:0] o_bf_twiddle,
  input  logic [2*DATA_WIDTH-1:0]    i_bf_data_a,
  input  logic [2*DATA_WIDTH-1:0]    i_bf_data_b,
  input  logic                       i_bf_valid,
  output logic                       o_wr_en,
  output logic [LOG2_N-1:0]          o_wr_addr_a,
  output logic [LOG2_N-1:0]          o_wr_addr_b,
  output logic [2*DATA_WIDTH-1:0]    o_wr_data_a,
  output logic [2*DATA_WIDTH-1:0]    o_wr_data_b
);
  import fft_pkg::*;

  localparam int KW     = LOG2_N - 1;
  localparam int SW     = (LOG2_N > 1) ? $clog2(LOG2_N) : 1;
  localparam int HALF_N = FFT_POINTS / 2;
  localparam int DL     = BFLY_LATENCY + 1;

  ctrl_state_e state, state_nxt;

  logic [SW-1:0]     stage;
  logic [KW-1:0]     k;
  logic [LOG2_N-1:0] wr_cnt;
  logic              bf_start_q;
  logic [LOG2_N-1:0] dl_a [DL];
  logic [LOG2_N-1:0] dl_b [DL];

  logic [LOG2_N-1:0] addr_a;
  logic [LOG2_N-1:0] addr_b;
  logic [KW-1:0]     tw_addr;

  logic run, active, wr_fire;
  logic last_k, last_wr, last_stage;

  fft_addr_gen #(
    .LOG2_N (LOG2_N),
    .SW     (SW)
  ) u_addr_gen (
    .stage   (stage),
    .k       (k),
    .addr_a  (addr_a),
    .addr_b  (addr_b),
    .tw_addr (tw_addr)
  );

  assign run        = (state == ST_RUN);
  assign active     = run || (state == ST_DRAIN);
  assign wr_fire    = active && i_bf_valid;
  assign last_k     = (k == KW'(HALF_N - 1));
  assign last_wr    = wr_fire && (wr_cnt == LOG2_N'(HALF_N - 1));
  assign last_stage = (stage == SW'(LOG2_N - 1));

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (i_start) state_nxt = ST_RUN;
      ST_RUN:   if (last_k) state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (last_wr) state_nxt = last_stage ? ST_DONE : ST_RUN;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      stage      <= '0;
      k          <= '0;
      wr_cnt     <= '0;
      bf_start_q <= 1'b0;
      for (int i = 0; i < DL; i++) begin
        dl_a[i] <= '0;
        dl_b[i] <= '0;
      end
    end else begin
      state      <= state_nxt;
      bf_start_q <= run;
      k          <= run ? k + KW'(1) : '0;
      if (state == ST_IDLE) stage <= '0;
      else if (last_wr && !last_stage) stage <= stage + SW'(1);
      if (!active || last_wr) wr_cnt <= '0;
      else if (wr_fire) wr_cnt <= wr_cnt + LOG2_N'(1);
      // addresses ride alongside the butterfly pipeline
      dl_a[0] <= run ? addr_a : '0;
      dl_b[0] <= run ? addr_b : '0;
      for (int i = 1; i < DL; i++) begin
        dl_a[i] <= dl_a[i-1];
        dl_b[i] <= dl_b[i-1];
      end
    end
  end

  assign o_busy       = active;
  assign o_done       = (state == ST_DONE);
  assign o_rd_en      = run;
  assign o_rd_addr_a  = run ? addr_a : '0;
  assign o_rd_addr_b  = run ? addr_b : '0;
  assign o_tw_addr    = run ? tw_addr : '0;
  assign o_bf_start   = bf_start_q;
  assign o_bf_data_a  = bf_start_q ? i_rd_data_a : '0;
  assign o_bf_data_b  = bf_start_q ? i_rd_data_b : '0;
  assign o_bf_twiddle = bf_start_q ? i_twiddle : '0;
  assign o_wr_en      = wr_fire;
  assign o_wr_addr_a  = wr_fire ? dl_a[DL-1] : '0;
  assign o_wr_addr_b  = wr_fire ? dl_b[DL-1] : '0;
  assign o_wr_data_a  = wr_fire ? i_bf_data_a : '0;
  assign o_wr_data_b  = wr_fire ? i_bf_data_b : '0;

endmodule

// File: tb/tb_fft_stage_controller.sv
// Bench for fft_stage_controller: N=8 with behavioural RAM, ROM and
// butterfly; scoreboard checks addresses, timing and final spectrum.
module tb_fft_stage_controller;
  import fft_pkg::*;

  localparam int N   = 8;
  localparam int L   = 3;
  localparam int DW  = DATA_WIDTH;
  localparam int TW  = TWIDDLE_WIDTH;
  localparam int LAT = BFLY_LATENCY;

  typedef logic [2*DW-1:0] word_t;
  typedef logic [2*TW-1:0] tw_t;
  typedef struct {
    logic [L-1:0] a;
    logic [L-1:0] b;
    logic [L-2:0] tw;
  } rd_t;
  typedef struct {
    logic [L-1:0] a;
    logic [L-1:0] b;
  } wr_t;

  logic clk = 1'b0;
  logic reset_n;
  logic i_start;
  logic o_busy, o_done, o_rd_en, o_bf_start, o_wr_en;
  logic [L-1:0] o_rd_addr_a, o_rd_addr_b, o_wr_addr_a, o_wr_addr_b;
  logic [L-2:0] o_tw_addr;
  word_t i_rd_data_a, i_rd_data_b, o_bf_data_a, o_bf_data_b;
  word_t i_bf_data_a, i_bf_data_b, o_wr_data_a, o_wr_data_b;
  tw_t   i_twiddle, o_bf_twiddle;
  logic  i_bf_valid;

  fft_stage_controller #(
    .FFT_POINTS    (N),
    .LOG2_N        (L),
    .DATA_WIDTH    (DW),
    .TWIDDLE_WIDTH (TW),
    .BFLY_LATENCY  (LAT)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_start      (i_start),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_rd_en      (o_rd_en),
    .o_rd_addr_a  (o_rd_addr_a),
    .o_rd_addr_b  (o_rd_addr_b),
    .i_rd_data_a  (i_rd_data_a),
    .i_rd_data_b  (i_rd_data_b),
    .o_tw_addr    (o_tw_addr),
    .i_twiddle    (i_twiddle),
    .o_bf_start   (o_bf_start),
    .o_bf_data_a  (o_bf_data_a),
    .o_bf_data_b  (o_bf_data_b),
    .o_bf_twiddle (o_bf_twiddle),
    .i_bf_data_a  (i_bf_data_a),
    .i_bf_data_b  (i_bf_data_b),
    .i_bf_valid   (i_bf_valid),
    .o_wr_en      (o_wr_en),
    .o_wr_addr_a  (o_wr_addr_a),
    .o_wr_addr_b  (o_wr_addr_b),
    .o_wr_data_a  (o_wr_data_a),
    .o_wr_data_b  (o_wr_data_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // radix-2 butterfly: A'=(a+w*b)/2, B'=(a-w*b)/2, product rounded
  function automatic logic [4*DW-1:0] bfly(word_t a, word_t b, tw_t w);
    longint ar, ai, br, bi, wr, wi, pr, pi;
    longint rnd;
    ar  = longint'(cplx_re(a));
    ai  = longint'(cplx_im(a));
    br  = longint'(cplx_re(b));
    bi  = longint'(cplx_im(b));
    wr  = longint'($signed(w[2*TW-1:TW]));
    wi  = longint'($signed(w[TW-1:0]));
    rnd = longint'(1) <<< (TW - 2);
    pr  = (br * wr - bi * wi + rnd) >>> (TW - 1);
    pi  = (br * wi + bi * wr + rnd) >>> (TW - 1);
    return {DW'((ar + pr) >>> 1), DW'((ai + pi) >>> 1),
            DW'((ar - pr) >>> 1), DW'((ai - pi) >>> 1)};
  endfunction

  function automatic longint q_round(real v);
    longint r;
    r = (v >= 0.0) ? longint'($rtoi(v + 0.5)) : -longint'($rtoi(-v + 0.5));
    if (r > (longint'(1) <<< (TW - 1)) - 1) r = (longint'(1) <<< (TW - 1)) - 1;
    return r;
  endfunction

  word_t ram [N];
  tw_t   rom [N/2];
  word_t rd_a = '0, rd_b = '0;
  tw_t   tw_r = '0;
  logic  ld_en = 1'b0;
  logic [L-1:0] ld_addr = '0;
  word_t ld_data = '0;

  always @(posedge clk) begin
    if (o_rd_en) begin
      rd_a <= ram[o_rd_addr_a];
      rd_b <= ram[o_rd_addr_b];
      tw_r <= rom[o_tw_addr];
    end
    if (ld_en) ram[ld_addr] <= ld_data;
    if (o_wr_en) begin
      ram[o_wr_addr_a] <= o_wr_data_a;
      ram[o_wr_addr_b] <= o_wr_data_b;
    end
  end
  assign i_rd_data_a = rd_a;
  assign i_rd_data_b = rd_b;
  assign i_twiddle   = tw_r;

  logic [4*DW-1:0] bf_res;
  word_t p_a [LAT];
  word_t p_b [LAT];
  logic [LAT-1:0] p_v = '0;
  logic inject = 1'b0;

  assign bf_res = bfly(o_bf_data_a, o_bf_data_b, o_bf_twiddle);
  always @(posedge clk) begin
    p_a[0] <= bf_res[4*DW-1:2*DW];
    p_b[0] <= bf_res[2*DW-1:0];
    p_v[0] <= o_bf_start;
    for (int i = 1; i < LAT; i++) begin
      p_a[i] <= p_a[i-1];
      p_b[i] <= p_b[i-1];
      p_v[i] <= p_v[i-1];
    end
  end
  assign i_bf_valid  = p_v[LAT-1] | inject;
  assign i_bf_data_a = p_a[LAT-1];
  assign i_bf_data_b = p_b[LAT-1];

  rd_t rd_q [$];
  wr_t wr_q [$];
  logic [L-2:0] bs_q [$];
  int wr_log [$];
  int done_log [$];
  int busy_cnt, busy_first, busy_last;
  int c0 = 0;
  word_t stim [N];
  word_t expv [N];

  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (o_rd_en) begin
          if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
          else begin
            rd_t e;
            e = rd_q.pop_front();
            chk("rd_addr", {o_rd_addr_a, o_rd_addr_b, o_tw_addr},
                {e.a, e.b, e.tw});
            bs_q.push_back(e.tw);
          end
        end
        if (o_bf_start) begin
          if (bs_q.size() == 0) chk("bf_unexpected", 1, 0);
          else begin
            logic [L-2:0] t;
            t = bs_q.pop_front();
            chk("bf_twiddle", o_bf_twiddle, rom[t]);
            chk("bf_operands", longint'(o_bf_data_a != rd_a || o_bf_data_b != rd_b), 0);
          end
        end
        if (o_wr_en) begin
          wr_log.push_back(cyc - c0);
          if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
          else begin
            wr_t e;
            e = wr_q.pop_front();
            chk("wr_addr", {o_wr_addr_a, o_wr_addr_b}, {e.a, e.b});
            chk("wr_data", longint'(o_wr_data_a != p_a[LAT-1] || o_wr_data_b != p_b[LAT-1]), 0);
          end
        end
        if (o_busy) begin
          busy_cnt++;
          if (busy_first < 0) busy_first = cyc - c0;
          busy_last = cyc - c0;
        end
        if (o_done) begin
          done_log.push_back(cyc - c0);
          chk("done_not_busy", o_busy, 0);
        end
      end
    end
  end

  function automatic int outs_ones();
    return $countones({o_busy, o_done, o_rd_en, o_rd_addr_a, o_rd_addr_b,
                       o_tw_addr, o_bf_start, o_bf_data_a, o_bf_data_b,
                       o_bf_twiddle, o_wr_en, o_wr_addr_a, o_wr_addr_b,
                       o_wr_data_a, o_wr_data_b});
  endfunction

  // textbook in-place DIT: groups of 2*half, twiddle stride N/(2*half)
  task automatic model();
    word_t m [N];
    for (int i = 0; i < N; i++) m[i] = stim[i];
    for (int s = 0; s < L; s++) begin
      int half;
      int step;
      half = 1 << s;
      step = N / (2 * half);
      for (int g = 0; g < N; g += 2 * half) begin
        for (int p = 0; p < half; p++) begin
          int a, b, t;
          logic [4*DW-1:0] r;
          a = g + p;
          b = a + half;
          t = p * step;
          rd_q.push_back('{a: L'(a), b: L'(b), tw: (L-1)'(t)});
          wr_q.push_back('{a: L'(a), b: L'(b)});
          r = bfly(m[a], m[b], rom[t]);
          m[a] = r[4*DW-1:2*DW];
          m[b] = r[2*DW-1:0];
        end
      end
    end
    for (int i = 0; i < N; i++) expv[i] = m[i];
  endtask

  task automatic run(input bit repulse, input int abort_at);
    bit aborted;
    int stage_len;
    aborted = 0;
    stage_len = N / 2 + LAT + 1;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      ld_en = 1'b1;
      ld_addr = L'(i);
      ld_data = stim[i];
    end
    @(negedge clk);
    ld_en = 1'b0;
    model();
    wr_log.delete();
    done_log.delete();
    busy_cnt = 0;
    busy_first = -1;
    busy_last = -1;
    @(negedge clk);
    #2;
    i_start = 1'b1;
    c0 = cyc + 1;
    for (int i = 0; i < 60 && done_log.size() == 0; i++) begin
      @(negedge clk);
      #2;
      i_start = repulse && (cyc == c0 + 10);
      if (abort_at > 0 && cyc == c0 + abort_at) begin
        reset_n = 1'b0;
        #1;
        chk("abort_outputs_zero", outs_ones(), 0);
        rd_q.delete();
        wr_q.delete();
        bs_q.delete();
        repeat (3) @(negedge clk);
        #2;
        reset_n = 1'b1;
        aborted = 1;
        break;
      end
    end
    if (aborted) return;
    if (done_log.size() == 0) chk("done_timeout", 1, 0);
    repeat (4) @(negedge clk);
    #2;
    chk("done_count", done_log.size(), 1);
    if (done_log.size() > 0) chk("done_cycle", done_log[0], L * stage_len);
    chk("busy_cycles", busy_cnt, L * stage_len);
    chk("busy_first", busy_first, 0);
    chk("busy_last", busy_last, L * stage_len - 1);
    chk("wr_count", wr_log.size(), L * N / 2);
    for (int i = 0; i < wr_log.size(); i++)
      chk("wr_cycle", wr_log[i],
          (i / (N / 2)) * stage_len + LAT + 1 + i % (N / 2));
    chk("queues_drained", rd_q.size() + wr_q.size() + bs_q.size(), 0);
    for (int i = 0; i < N; i++) chk("bin_model", ram[i], expv[i]);
  endtask

  task automatic idle_inject();
    @(negedge clk);
    #2;
    inject = 1'b1;
    #1;
    chk("idle_valid_no_write", o_wr_en, 0);
    @(negedge clk);
    #2;
    inject = 1'b0;
  endtask

  task automatic set_impulse();
    for (int i = 0; i < N; i++) stim[i] = '0;
    stim[0] = cplx_pack(DW'(800), DW'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    i_start = 1'b0;
    for (int k = 0; k < N / 2; k++) begin
      real ang;
      longint cr, ci;
      ang = 2.0 * 3.14159265358979 * k / N;
      cr = q_round($cos(ang) * 8388608.0);
      ci = q_round(-$sin(ang) * 8388608.0);
      rom[k] = {TW'(cr), TW'(ci)};
    end
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs_zero", outs_ones(), 0);
    #1;
    reset_n = 1'b1;

    set_impulse();
    run(0, 0);
    for (int i = 0; i < N; i++)
      chk("impulse_bin", ram[i], cplx_pack(DW'(100), DW'(0)));

    for (int i = 0; i < N; i++) stim[i] = cplx_pack(DW'(80), DW'(0));
    run(1, 0);
    for (int i = 0; i < N; i++)
      chk("dc_bin", ram[i], (i == 0) ? cplx_pack(DW'(80), DW'(0)) : '0);

    set_impulse();
    run(0, 14);
    idle_inject();
    set_impulse();
    run(0, 0);
    for (int i = 0; i < N; i++)
      chk("post_reset_impulse_bin", ram[i], cplx_pack(DW'(100), DW'(0)));

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N; i++) begin
        int re, im;
        re = int'($urandom_range(0, 2 ** 21)) - 2 ** 20;
        im = int'($urandom_range(0, 2 ** 21)) - 2 ** 20;
        stim[i] = cplx_pack(DW'(re), DW'(im));
      end
      repeat ($urandom_range(1, 5)) @(negedge clk);
      idle_inject();
      run(r[0], 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
